// File: rtl/calc_resp_merge.sv
// calc_resp_merge: merges NCH response channels, each buffered in its own FIFO, onto one registered port.
// Latency: 2 cycles from the input sample edge to the output (write edge, then grant edge). There is no bypass.
// Backpressure: none toward the sources. A push to a full FIFO that is not popped is dropped and flagged in ovf.

// calc_resp_merge_fifo: generic DEPTH-entry FIFO with pointers that wrap and an occupancy count.
// Latency: an entry written at edge k is visible on head_* after edge k; pop is combinational on the head.
// Backpressure: a push to a full FIFO is accepted only when a pop happens at the same edge; otherwise drop pulses.
module calc_resp_merge_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         c_clk,
  input  logic         reset,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;
  logic          do_push;

  assign head_vld = (cnt_q != '0);
  assign head_dat = mem_q[rd_ptr_q];

  // Next-state: a pop frees the head slot first, so a full FIFO can take a push on the same edge
  always_comb begin
    do_pop   = pop_rdy && (cnt_q != '0);
    do_push  = push_vld && ((cnt_q != CW'(DEPTH)) || do_pop);
    drop     = push_vld && !do_push;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; reset empties the FIFO and discards anything buffered
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      for (int j = 0; j < DEPTH; j++) begin
        mem_q[j] <= mem_d[j];
      end
    end
  end
endmodule

module calc_resp_merge #(
  parameter int NCH      = 4,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 1
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic [2*NCH-1:0]         in_resp,
  input  logic [DW*NCH-1:0]        in_data,
  output logic [1:0]               out_resp,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(NCH)-1:0]   out_chan,
  output logic [NCH-1:0]           ovf
);
  localparam int CHW = $clog2(NCH);

  typedef struct packed {
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } ent_t;

  ent_t           push_dat [NCH];
  ent_t           head_dat [NCH];
  logic [NCH-1:0] push_vld;
  logic [NCH-1:0] head_vld;
  logic [NCH-1:0] pop_rdy;
  logic [NCH-1:0] drop;

  logic           gnt_vld;
  logic [CHW-1:0] gnt_idx;

  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]     out_resp_q, out_resp_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic [CHW-1:0] out_chan_q, out_chan_d;
  logic [NCH-1:0] ovf_q, ovf_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // A zero response code means no response, so it is never stored
    assign push_vld[i]      = (in_resp[2*i +: 2] != 2'b00);
    assign push_dat[i].resp = in_resp[2*i +: 2];
    assign push_dat[i].data = in_data[DW*i +: DW];

    calc_resp_merge_fifo #(
      .W     ($bits(ent_t)),
      .DEPTH (DEPTH)
    ) u_fifo (
      .c_clk    (c_clk),
      .reset    (reset),
      .push_vld (push_vld[i]),
      .push_dat (push_dat[i]),
      .pop_rdy  (pop_rdy[i]),
      .head_vld (head_vld[i]),
      .head_dat (head_dat[i]),
      .drop     (drop[i])
    );
  end

  // Arbiter: pick one non-empty FIFO, either lowest index or the first one found starting at rr_ptr
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (ARB_MODE == 0) begin
      // Scan downward so the lowest eligible index is the last one written
      for (int i = NCH - 1; i >= 0; i--) begin
        if (head_vld[CHW'(i)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CHW'(i);
        end
      end
    end else begin
      // Scan the rotated order downward so the first channel at or after rr_ptr wins
      for (int k = NCH - 1; k >= 0; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NCH) begin
          idx = idx - NCH;
        end
        if (head_vld[CHW'(idx)]) begin
          gnt_vld = 1'b1;
          gnt_idx = CHW'(idx);
        end
      end
    end
    pop_rdy = gnt_vld ? (NCH'(1) << gnt_idx) : '0;
  end

  // Output and pointer next-state: load the granted head entry, or the idle pattern when nothing is granted
  always_comb begin
    out_resp_d = 2'b00;
    out_data_d = '0;
    out_chan_d = '0;
    rr_ptr_d   = rr_ptr_q;
    if (gnt_vld) begin
      out_resp_d = head_dat[gnt_idx].resp;
      out_data_d = head_dat[gnt_idx].data;
      out_chan_d = gnt_idx;
      rr_ptr_d   = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + CHW'(1);
    end
    ovf_d = ovf_q | drop;
  end

  // Registered outputs, round-robin pointer and sticky overflow flags
  always_ff @(posedge c_clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      out_resp_q <= 2'b00;
      out_data_q <= '0;
      out_chan_q <= '0;
      ovf_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      out_resp_q <= out_resp_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_chan = out_chan_q;
  assign ovf      = ovf_q;

  // Idle cycles must carry an all-zero payload and channel index
  a_idle_clean : assert property (@(posedge c_clk) disable iff (reset)
    (out_resp_q == 2'b00) |-> ((out_data_q == '0) && (out_chan_q == '0)));
endmodule

// File: tb/tb_calc_resp_merge.sv
// tb_calc_resp_merge: drives a fixed-priority and a round-robin instance with the same stimulus.
// A queue-based reference model predicts each instance's registered outputs edge by edge.
// Directed phases pin literal expectations, then a randomized phase runs against the model alone.
module tb_calc_resp_merge;
  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef logic [DW+1:0] ent_t;

  logic                  c_clk = 1'b0;
  logic                  reset;
  logic [2*NCH-1:0]      in_resp;
  logic [DW*NCH-1:0]     in_data;
  logic [1:0][1:0]       o_resp;
  logic [1:0][DW-1:0]    o_data;
  logic [1:0][1:0]       o_chan;
  logic [1:0][NCH-1:0]   o_ovf;

  int vectors = 0;
  int errs    = 0;

  always #5 c_clk = ~c_clk;

  calc_resp_merge #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(0)) dut0 (
    .c_clk(c_clk), .reset(reset), .in_resp(in_resp), .in_data(in_data),
    .out_resp(o_resp[0]), .out_data(o_data[0]), .out_chan(o_chan[0]), .ovf(o_ovf[0])
  );

  calc_resp_merge #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .ARB_MODE(1)) dut1 (
    .c_clk(c_clk), .reset(reset), .in_resp(in_resp), .in_data(in_data),
    .out_resp(o_resp[1]), .out_data(o_data[1]), .out_chan(o_chan[1]), .ovf(o_ovf[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model: one set of queues per instance ----------------
  ent_t           mq [2*NCH][$];
  int             rr [2];
  logic [NCH-1:0] m_ovf [2];
  logic [1:0]     e_resp [2];
  logic [DW-1:0]  e_data [2];
  logic [1:0]     e_chan [2];
  bit             model_ok = 1'b0;

  initial begin
    int   g;
    int   c;
    ent_t e;
    forever begin
      @(posedge c_clk);
      for (int m = 0; m < 2; m++) begin
        if (reset) begin
          for (int i = 0; i < NCH; i++) mq[m*NCH+i].delete();
          rr[m]     = 0;
          m_ovf[m]  = '0;
          e_resp[m] = 2'b00;
          e_data[m] = '0;
          e_chan[m] = '0;
        end else begin
          // grant decided on the queue contents before this edge's pushes
          g = -1;
          for (int k = 0; k < NCH; k++) begin
            c = (m == 0) ? k : (rr[m] + k) % NCH;
            if (g < 0 && mq[m*NCH+c].size() > 0) g = c;
          end
          if (g >= 0) begin
            e         = mq[m*NCH+g].pop_front();
            e_resp[m] = e[DW+1:DW];
            e_data[m] = e[DW-1:0];
            e_chan[m] = 2'(g);
            rr[m]     = (g + 1) % NCH;
          end else begin
            e_resp[m] = 2'b00;
            e_data[m] = '0;
            e_chan[m] = '0;
          end
          for (int i = 0; i < NCH; i++) begin
            if (in_resp[2*i +: 2] != 2'b00) begin
              if (mq[m*NCH+i].size() < DEPTH)
                mq[m*NCH+i].push_back({in_resp[2*i +: 2], in_data[DW*i +: DW]});
              else
                m_ovf[m][i] = 1'b1;
            end
          end
        end
      end
      if (reset) model_ok = 1'b1;
    end
  end

  // ---------------- compare process: every cycle after the first reset edge ----------------
  int emitted [2][NCH];

  always @(negedge c_clk) begin
    if (model_ok) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("dut%0d.out_resp", m), 64'(o_resp[m]), 64'(e_resp[m]));
        chk($sformatf("dut%0d.out_data", m), 64'(o_data[m]), 64'(e_data[m]));
        chk($sformatf("dut%0d.out_chan", m), 64'(o_chan[m]), 64'(e_chan[m]));
        chk($sformatf("dut%0d.ovf", m),      64'(o_ovf[m]),  64'(m_ovf[m]));
        if (o_resp[m] != 2'b00) emitted[m][o_chan[m]]++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_idle();
    in_resp = '0;
    for (int i = 0; i < NCH; i++) in_data[DW*i +: DW] = $urandom;
  endtask

  task automatic set_ch(input int ch, input logic [1:0] code, input logic [DW-1:0] dat);
    in_resp[2*ch +: 2] = code;
    in_data[DW*ch +: DW] = dat;
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    repeat (n) @(negedge c_clk);
  endtask

  initial begin
    int snap [2][NCH];
    int dens;

    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NCH; i++) emitted[m][i] = 0;

    // Reset held 2 cycles with every channel presenting a response: all must be ignored
    reset = 1'b1;
    drive_idle();
    for (int i = 0; i < NCH; i++) set_ch(i, 2'b01, $urandom);
    repeat (2) @(posedge c_clk);
    @(negedge c_clk);
    reset = 1'b0;
    drive_idle();
    for (int n = 0; n < 3; n++) begin
      @(negedge c_clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rst_resp%0d", m), 64'(o_resp[m]), 64'd0);
        chk($sformatf("rst_data%0d", m), 64'(o_data[m]), 64'd0);
        chk($sformatf("rst_ovf%0d", m),  64'(o_ovf[m]),  64'd0);
      end
    end

    // Single response on channel 2: visible after the second edge, for exactly one cycle
    set_ch(2, 2'b01, 32'h0000_00AA);
    @(negedge c_clk);
    drive_idle();
    @(negedge c_clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("lat_resp%0d", m), 64'(o_resp[m]), 64'h1);
      chk($sformatf("lat_data%0d", m), 64'(o_data[m]), 64'hAA);
      chk($sformatf("lat_chan%0d", m), 64'(o_chan[m]), 64'h2);
    end
    @(negedge c_clk);
    for (int m = 0; m < 2; m++)
      chk($sformatf("lat_pulse%0d", m), 64'(o_resp[m]), 64'h0);

    // Bring the round-robin pointer back to 0 with one grant on channel 3
    set_ch(3, 2'b01, $urandom);
    @(negedge c_clk);
    idle_cycles(4);

    // Simultaneous burst twice: round-robin order 0,1,2,3 both times
    for (int rep = 0; rep < 2; rep++) begin
      for (int i = 0; i < NCH; i++) set_ch(i, 2'b01, DW'(i));
      @(negedge c_clk);
      drive_idle();
      for (int j = 0; j < NCH; j++) begin
        @(negedge c_clk);
        chk($sformatf("rr_chan_r%0d_%0d", rep, j), 64'(o_chan[1]), 64'(j));
        chk($sformatf("rr_data_r%0d_%0d", rep, j), 64'(o_data[1]), 64'(j));
      end
    end
    idle_cycles(3);

    // Fixed priority: channel 0 fed every cycle for 6 cycles starves channel 3 until it drains
    for (int j = 0; j < 9; j++) begin
      if (j >= 2 && j <= 7) begin
        chk($sformatf("fp_chan_%0d", j), 64'(o_chan[0]), 64'h0);
        chk($sformatf("fp_data_%0d", j), 64'(o_data[0]), 64'(32'h100 + j - 2));
        chk($sformatf("fp_resp_%0d", j), 64'(o_resp[0]), 64'h2);
      end
      if (j == 8) begin
        chk("fp_ch3_chan", 64'(o_chan[0]), 64'h3);
        chk("fp_ch3_data", 64'(o_data[0]), 64'h333);
        chk("fp_ch3_resp", 64'(o_resp[0]), 64'h3);
      end
      drive_idle();
      if (j < 6) set_ch(0, 2'b10, 32'h100 + j);
      if (j == 0) set_ch(3, 2'b11, 32'h333);
      @(negedge c_clk);
    end
    idle_cycles(4);

    // Overflow: every channel pushes for 6 cycles; fixed priority keeps only channel 0 drained
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NCH; i++) snap[m][i] = emitted[m][i];
    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < NCH; i++) set_ch(i, 2'($urandom_range(1, 3)), $urandom);
      @(negedge c_clk);
    end
    idle_cycles(30);
    chk("ovf_fixed", 64'(o_ovf[0]), 64'b1110);
    chk("ovf_cnt_ch0", 64'(emitted[0][0] - snap[0][0]), 64'd6);
    for (int i = 1; i < NCH; i++)
      chk($sformatf("ovf_cnt_ch%0d", i), 64'(emitted[0][i] - snap[0][i]), 64'(DEPTH));

    // Reset mid-operation: three buffered entries are discarded, ovf clears
    set_ch(1, 2'b01, 32'h11);
    set_ch(2, 2'b01, 32'h22);
    set_ch(3, 2'b01, 32'h33);
    @(negedge c_clk);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) set_ch(i, 2'b01, $urandom);
    @(negedge c_clk);
    reset = 1'b0;
    drive_idle();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("mrst_ovf%0d", m),  64'(o_ovf[m]),  64'h0);
      chk($sformatf("mrst_resp%0d", m), 64'(o_resp[m]), 64'h0);
    end
    @(negedge c_clk);
    for (int m = 0; m < 2; m++)
      chk($sformatf("mrst_flush%0d", m), 64'(o_resp[m]), 64'h0);
    set_ch(0, 2'b01, 32'h55);
    @(negedge c_clk);
    drive_idle();
    @(negedge c_clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("mrst_new_data%0d", m), 64'(o_data[m]), 64'h55);
      chk($sformatf("mrst_new_chan%0d", m), 64'(o_chan[m]), 64'h0);
    end
    idle_cycles(3);

    // Randomized traffic with varying density and occasional resets
    for (int seg = 0; seg < 12; seg++) begin
      dens = $urandom_range(10, 90);
      for (int n = 0; n < 250; n++) begin
        reset = ($urandom_range(0, 499) == 0);
        drive_idle();
        for (int i = 0; i < NCH; i++)
          if ($urandom_range(0, 99) < dens) set_ch(i, 2'($urandom_range(1, 3)), $urandom);
        @(negedge c_clk);
      end
    end
    reset = 1'b0;
    idle_cycles(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/calc_resp_merge.md
# calc_resp_merge

Parametrised response merger for the calc1 output path. It collects response/data pulses from NCH independent result channels, buffers each channel in its own DEPTH-entry FIFO, and drives one registered output port with one response per cycle. Arbitration between channels is selectable: fixed priority or round-robin. Responses that arrive together are never lost unless a channel's FIFO overflows, and overflow is flagged per channel.

## Interface
- NCH, 4: number of input channels, 2..8
- DW, 32: data width
- DEPTH, 4: per-channel FIFO entries, power of two, >= 2
- ARB_MODE, 1: 0 = fixed priority (lowest channel index wins); 1 = round-robin
- c_clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_resp  in  2*NCH  channel i response code at bits [2i:2i+1]; non-zero means a valid response this cycle
- in_data  in  DW*NCH  channel i data at bits [DW*i : DW*i+DW-1]
- out_resp  out  2  merged response code; 2'b00 = idle
- out_data  out  DW  data paired with out_resp; all zeros when idle
- out_chan  out  clog2(NCH)  index of the source channel; 0 when idle
- ovf  out  NCH  sticky per-channel overflow flag

## Operation
- **Push:** at each edge where in_resp of channel i is non-zero, the pair {resp, data} is written to FIFO i. A code of 2'b00 is never stored.
- **Eligibility:** a channel is eligible when its FIFO is non-empty.
- **Grant:** at most one channel is granted per cycle.
  - ARB_MODE=0: grant the lowest eligible index.
  - ARB_MODE=1: search starting at rr_ptr, wrapping at NCH-1 to 0. After a grant, rr_ptr becomes grant+1 modulo NCH. rr_ptr is unchanged when nothing is granted.
- **Pop and output:** on a grant, the head entry of the granted FIFO is popped. out_resp, out_data and out_chan load that entry and index at the same edge. With no grant, the outputs load 2'b00, all zeros, and 0.
- **Full FIFO:**
  - A push to a full FIFO that is not popped at the same edge is dropped, and ovf[i] is set.
  - A push to a full FIFO that is popped at the same edge is accepted; the count stays DEPTH.
- **Empty FIFO:** a push to an empty FIFO cannot be granted at the same edge. There is no bypass.
- **ovf:** cleared only by reset.
- **FIFO storage:** each FIFO has a read pointer and a write pointer of width clog2(DEPTH), which wrap modulo DEPTH, plus a count of width clog2(DEPTH)+1.
- **Reset:**
  - Synchronous reset clears all FIFOs (pointers and counts to 0), rr_ptr to 0, ovf to 0, out_resp to 2'b00, out_data to 0 and out_chan to 0.
  - in_resp is ignored during any cycle in which reset is high.
  - Reset asserted mid-operation discards all buffered entries. No output appears on the cycle after reset deasserts unless pushed data has aged in as described under Timing.

## Timing
- A response sampled at edge k is written to the FIFO at edge k. It can be granted at the earliest at edge k+1, so it appears on out_resp during the cycle after edge k+1 (2-cycle latency).
- Each output response is a single-cycle pulse. Back-to-back grants produce consecutive non-zero cycles.
- Throughput: one response per cycle in aggregate. Each channel is drained at up to one entry per cycle.
- Round-robin bound: an eligible channel is granted within NCH cycles.
- Order within one channel is strictly preserved (FIFO). Order across channels is set by arbitration only.
- The outputs are fully registered; there is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** hold reset 2 cycles with in_resp all 2'b01 -> out_resp 00, out_data 0, out_chan 0, ovf 0, and nothing emitted after release.
- **Single response latency:** channel 2 sends resp 01, data 0x0000_00AA at edge 10 -> out_resp 01, out_data 0xAA, out_chan 2 after edge 11 for exactly one cycle.
- **Simultaneous round-robin:** all 4 channels send resp 01 with data = index at the same edge, rr_ptr=0, ARB_MODE=1 -> outputs chan 0,1,2,3 on 4 consecutive cycles. Repeat the burst -> the order continues 0,1,2,3 because rr_ptr has wrapped to 0.
- **Fixed priority:** ARB_MODE=0, channel 0 receives a new response every cycle and channel 3 has one pending -> channel 3 waits until channel 0's FIFO is empty. Also check that channel 0's entries emerge in FIFO order.
- **Overflow:** DEPTH=4, four channels each push every cycle for 6 cycles -> ovf bits set for starved channels. Check the per-channel count of emitted responses equals accepted pushes; dropped entries never appear.
- **Reset mid-operation:** three entries are buffered and reset is pulsed for 1 cycle -> no buffered entries are emitted afterwards, ovf returns to 0, and a new push 2 cycles later emits normally.
